// File: rtl/keypad_pkg.sv
// Shared keypad definitions for the calculator blocks.
// Holds the raw keycode values, the operator encodings carried on opcode,
// and the entry FSM state encodings.
package keypad_pkg;

  // Raw keycodes. Any code with bit 4 set is a hex digit (value in [3:0]).
  localparam logic [4:0] KEY_BS  = 5'b00001;
  localparam logic [4:0] KEY_MUL = 5'b00010;
  localparam logic [4:0] KEY_SUB = 5'b00011;
  localparam logic [4:0] KEY_EQ  = 5'b00100;
  localparam logic [4:0] KEY_ADD = 5'b01010;

  // Operator encodings as presented to the arithmetic consumer.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  // Entry FSM states.
  localparam logic [1:0] S_A    = 2'd0;
  localparam logic [1:0] S_B    = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/keypad_decode.sv
// Combinational keycode classifier.
// Ports:
//   keycode - raw 5-bit key
//   is_hex  - key is a hex digit, value on hex
//   is_op   - key is an operator, encoding on op
//   is_eq   - key is equals
//   is_bs   - key is backspace
// Unrecognised codes leave every flag low.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [4:0] keycode,
  output logic       is_hex,
  output logic [3:0] hex,
  output logic       is_op,
  output logic [1:0] op,
  output logic       is_eq,
  output logic       is_bs
);

  // Hex codes all have bit 4 set, so they can never alias the command keys.
  always_comb begin
    is_hex = keycode[4];
    hex    = keycode[3:0];
    is_op  = 1'b0;
    op     = OP_ADD;
    is_eq  = 1'b0;
    is_bs  = 1'b0;
    case (keycode)
      KEY_ADD: begin is_op = 1'b1; op = OP_ADD; end
      KEY_MUL: begin is_op = 1'b1; op = OP_MUL; end
      KEY_SUB: begin is_op = 1'b1; op = OP_SUB; end
      KEY_EQ:  is_eq = 1'b1;
      KEY_BS:  is_bs = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad command entry: collects "A op B =" from keypresses and offers the
// finished command on a valid/ready handshake.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   newkey, keycode     - one-cycle keypress strobe and its code
//   operand_a/operand_b - right-justified hex operands
//   opcode              - latched operator
//   display, ndigits    - operand being entered and its digit count
//   cmd_valid/cmd_ready - command handshake
//   overflow            - pulse when a digit is dropped on a full operand
// Every output is a register; it reflects a key on the edge after the key.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int CW      = $clog2(NDIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newkey,
  input  logic [4:0]           keycode,
  output logic [4*NDIGITS-1:0] operand_a,
  output logic [4*NDIGITS-1:0] operand_b,
  output logic [1:0]           opcode,
  output logic [4*NDIGITS-1:0] display,
  output logic [CW-1:0]        ndigits,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 overflow
);

  localparam int W = 4 * NDIGITS;
  localparam logic [CW-1:0] FULL = CW'(NDIGITS);

  logic          is_hex, is_op, is_eq, is_bs;
  logic [3:0]    hex;
  logic [1:0]    op;

  logic [1:0]    state, state_n;
  logic [CW-1:0] acnt, acnt_n, bcnt, bcnt_n;
  logic [W-1:0]  a_n, b_n;
  logic [1:0]    op_n;
  logic          valid_n, ovf_n;

  keypad_decode u_decode (
    .keycode (keycode),
    .is_hex  (is_hex),
    .hex     (hex),
    .is_op   (is_op),
    .op      (op),
    .is_eq   (is_eq),
    .is_bs   (is_bs)
  );

  // Next-state and datapath. A full operand drops the new digit and flags it.
  always_comb begin
    state_n = state;
    a_n     = operand_a;
    b_n     = operand_b;
    acnt_n  = acnt;
    bcnt_n  = bcnt;
    op_n    = opcode;
    valid_n = cmd_valid;
    ovf_n   = 1'b0;
    case (state)
      S_A: begin
        if (newkey) begin
          if (is_hex) begin
            if (acnt == FULL) begin
              ovf_n = 1'b1;
            end else begin
              a_n    = (operand_a << 4) | W'(hex);
              acnt_n = acnt + CW'(1);
            end
          end else if (is_bs) begin
            if (acnt != '0) begin
              a_n    = operand_a >> 4;
              acnt_n = acnt - CW'(1);
            end
          end else if (is_op) begin
            if (acnt != '0) begin
              op_n    = op;
              state_n = S_B;
            end
          end
        end
      end
      S_B: begin
        if (newkey) begin
          if (is_hex) begin
            if (bcnt == FULL) begin
              ovf_n = 1'b1;
            end else begin
              b_n    = (operand_b << 4) | W'(hex);
              bcnt_n = bcnt + CW'(1);
            end
          end else if (is_bs) begin
            // Backspacing past an empty B reopens A for editing.
            if (bcnt != '0) begin
              b_n    = operand_b >> 4;
              bcnt_n = bcnt - CW'(1);
            end else begin
              state_n = S_A;
            end
          end else if (is_op) begin
            // The operator can only be changed before B has any digits.
            if (bcnt == '0) op_n = op;
          end else if (is_eq) begin
            if (bcnt != '0) begin
              state_n = S_HOLD;
              valid_n = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        // Keys are discarded here, even one coinciding with the handshake.
        if (cmd_ready) begin
          state_n = S_A;
          a_n     = '0;
          b_n     = '0;
          acnt_n  = '0;
          bcnt_n  = '0;
          op_n    = OP_ADD;
          valid_n = 1'b0;
        end
      end
      default: state_n = S_A;
    endcase
  end

  // State and output registers; display/ndigits follow the next state so
  // they stay aligned with the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_A;
      operand_a <= '0;
      operand_b <= '0;
      acnt      <= '0;
      bcnt      <= '0;
      opcode    <= OP_ADD;
      cmd_valid <= 1'b0;
      overflow  <= 1'b0;
      display   <= '0;
      ndigits   <= '0;
    end else begin
      state     <= state_n;
      operand_a <= a_n;
      operand_b <= b_n;
      acnt      <= acnt_n;
      bcnt      <= bcnt_n;
      opcode    <= op_n;
      cmd_valid <= valid_n;
      overflow  <= ovf_n;
      display   <= (state_n == S_A) ? a_n : b_n;
      ndigits   <= (state_n == S_A) ? acnt_n : bcnt_n;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry (NDIGITS=4): a table of per-cycle
// vectors with hand-computed expected outputs, plus hand-written sequences.
module tb_keypad_entry;

  localparam logic [4:0] K_BS  = 5'b00001;
  localparam logic [4:0] K_MUL = 5'b00010;
  localparam logic [4:0] K_SUB = 5'b00011;
  localparam logic [4:0] K_EQ  = 5'b00100;
  localparam logic [4:0] K_ADD = 5'b01010;

  logic        clk = 1'b0;
  logic        rst;
  logic        newkey;
  logic [4:0]  keycode;
  logic        cmd_ready;
  logic [15:0] operand_a, operand_b, display;
  logic [1:0]  opcode;
  logic [2:0]  ndigits;
  logic        cmd_valid, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        nk;
    logic [4:0]  key;
    logic        rdy;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [1:0]  eop;
    logic [15:0] ed;
    logic [2:0]  en;
    logic        ev;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  keypad_entry #(.NDIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .newkey    (newkey),
    .keycode   (keycode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .display   (display),
    .ndigits   (ndigits),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] hk(input logic [3:0] d);
    return {1'b1, d};
  endfunction

  task automatic v(input logic r, input logic nk, input logic [4:0] key,
                   input logic rdy, input logic [15:0] ea, input logic [15:0] eb,
                   input logic [1:0] eop, input logic [15:0] ed,
                   input logic [2:0] en, input logic ev, input logic eo);
    vecs.push_back('{r, nk, key, rdy, ea, eb, eop, ed, en, ev, eo});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic nk,
                               input logic [4:0] key, input logic rdy);
    rst       = r;
    newkey    = nk;
    keycode   = key;
    cmd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int unsigned act,
                     input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] ea,
                             input logic [15:0] eb, input logic [1:0] eop,
                             input logic [15:0] ed, input logic [2:0] en,
                             input logic ev, input logic eo);
    cmp({tag, " operand_a"}, operand_a, ea);
    cmp({tag, " operand_b"}, operand_b, eb);
    cmp({tag, " opcode"},    opcode,    eop);
    cmp({tag, " display"},   display,   ed);
    cmp({tag, " ndigits"},   ndigits,   en);
    cmp({tag, " cmd_valid"}, cmd_valid, ev);
    cmp({tag, " overflow"},  overflow,  eo);
  endtask

  task automatic pressKey(input logic [4:0] key, input logic rdy);
    applyStimulus(1'b0, 1'b1, key, rdy);
  endtask

  initial begin
    rst = 1'b1; newkey = 1'b0; keycode = '0; cmd_ready = 1'b0;

    //  rst nk key       rdy  opA      opB      op     disp     nd   v  ovf
    v(1, 0, 5'd0,     0, 16'h0,    16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    // 1 2 + 3 = then handshake; idle key and stray ready have no effect
    v(0, 1, hk(4'h1), 0, 16'h1,    16'h0,    2'b00, 16'h1,    3'd1, 0, 0);
    v(0, 1, hk(4'h2), 0, 16'h12,   16'h0,    2'b00, 16'h12,   3'd2, 0, 0);
    v(0, 0, hk(4'h9), 0, 16'h12,   16'h0,    2'b00, 16'h12,   3'd2, 0, 0);
    v(0, 0, 5'd0,     1, 16'h12,   16'h0,    2'b00, 16'h12,   3'd2, 0, 0);
    v(0, 1, K_ADD,    0, 16'h12,   16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    v(0, 1, hk(4'h3), 0, 16'h12,   16'h3,    2'b00, 16'h3,    3'd1, 0, 0);
    v(0, 1, K_EQ,     0, 16'h12,   16'h3,    2'b00, 16'h3,    3'd1, 1, 0);
    v(0, 0, 5'd0,     0, 16'h12,   16'h3,    2'b00, 16'h3,    3'd1, 1, 0);
    v(0, 0, 5'd0,     1, 16'h0,    16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    // 1 2 3 4 5: fifth digit dropped with a single overflow pulse
    v(0, 1, hk(4'h1), 0, 16'h1,    16'h0,    2'b00, 16'h1,    3'd1, 0, 0);
    v(0, 1, hk(4'h2), 0, 16'h12,   16'h0,    2'b00, 16'h12,   3'd2, 0, 0);
    v(0, 1, hk(4'h3), 0, 16'h123,  16'h0,    2'b00, 16'h123,  3'd3, 0, 0);
    v(0, 1, hk(4'h4), 0, 16'h1234, 16'h0,    2'b00, 16'h1234, 3'd4, 0, 0);
    v(0, 1, hk(4'h5), 0, 16'h1234, 16'h0,    2'b00, 16'h1234, 3'd4, 0, 1);
    v(0, 0, 5'd0,     0, 16'h1234, 16'h0,    2'b00, 16'h1234, 3'd4, 0, 0);
    v(1, 0, 5'd0,     0, 16'h0,    16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    // A B bs x bs bs, then empty-A bs / = / op all ignored
    v(0, 1, hk(4'hA), 0, 16'hA,    16'h0,    2'b00, 16'hA,    3'd1, 0, 0);
    v(0, 1, hk(4'hB), 0, 16'hAB,   16'h0,    2'b00, 16'hAB,   3'd2, 0, 0);
    v(0, 1, K_BS,     0, 16'hA,    16'h0,    2'b00, 16'hA,    3'd1, 0, 0);
    v(0, 1, K_MUL,    0, 16'hA,    16'h0,    2'b01, 16'h0,    3'd0, 0, 0);
    v(0, 1, K_BS,     0, 16'hA,    16'h0,    2'b01, 16'hA,    3'd1, 0, 0);
    v(0, 1, K_BS,     0, 16'h0,    16'h0,    2'b01, 16'h0,    3'd0, 0, 0);
    v(0, 1, K_BS,     0, 16'h0,    16'h0,    2'b01, 16'h0,    3'd0, 0, 0);
    v(0, 1, K_EQ,     0, 16'h0,    16'h0,    2'b01, 16'h0,    3'd0, 0, 0);
    v(0, 1, K_ADD,    0, 16'h0,    16'h0,    2'b01, 16'h0,    3'd0, 0, 0);
    v(1, 0, 5'd0,     0, 16'h0,    16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    // 7 + - = 5 x = then stall with 9 ignored, handshake with 9 ignored
    v(0, 1, hk(4'h7), 0, 16'h7,    16'h0,    2'b00, 16'h7,    3'd1, 0, 0);
    v(0, 1, K_ADD,    0, 16'h7,    16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    v(0, 1, K_SUB,    0, 16'h7,    16'h0,    2'b10, 16'h0,    3'd0, 0, 0);
    v(0, 1, K_EQ,     0, 16'h7,    16'h0,    2'b10, 16'h0,    3'd0, 0, 0);
    v(0, 1, hk(4'h5), 0, 16'h7,    16'h5,    2'b10, 16'h5,    3'd1, 0, 0);
    v(0, 1, K_MUL,    0, 16'h7,    16'h5,    2'b10, 16'h5,    3'd1, 0, 0);
    v(0, 1, K_EQ,     0, 16'h7,    16'h5,    2'b10, 16'h5,    3'd1, 1, 0);
    v(0, 1, hk(4'h9), 0, 16'h7,    16'h5,    2'b10, 16'h5,    3'd1, 1, 0);
    v(0, 0, 5'd0,     0, 16'h7,    16'h5,    2'b10, 16'h5,    3'd1, 1, 0);
    v(0, 1, hk(4'h9), 1, 16'h0,    16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    // 3 4 + 1 then reset with a coincident key
    v(0, 1, hk(4'h3), 0, 16'h3,    16'h0,    2'b00, 16'h3,    3'd1, 0, 0);
    v(0, 1, hk(4'h4), 0, 16'h34,   16'h0,    2'b00, 16'h34,   3'd2, 0, 0);
    v(0, 1, K_ADD,    0, 16'h34,   16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    v(0, 1, hk(4'h1), 0, 16'h34,   16'h1,    2'b00, 16'h1,    3'd1, 0, 0);
    v(1, 1, hk(4'h5), 0, 16'h0,    16'h0,    2'b00, 16'h0,    3'd0, 0, 0);
    v(0, 1, hk(4'h6), 0, 16'h6,    16'h0,    2'b00, 16'h6,    3'd1, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].nk, vecs[i].key, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb,
                  vecs[i].eop, vecs[i].ed, vecs[i].en, vecs[i].ev, vecs[i].eo);
    end

    // B fills up and overflows, then backspace trims it (A=6 from above).
    pressKey(K_MUL, 1'b0);
    for (int d = 1; d <= 4; d++) pressKey(hk(4'(d)), 1'b0);
    checkOutput("bfull", 16'h6, 16'h1234, 2'b01, 16'h1234, 3'd4, 1'b0, 1'b0);
    pressKey(hk(4'hF), 1'b0);
    checkOutput("bovf", 16'h6, 16'h1234, 2'b01, 16'h1234, 3'd4, 1'b0, 1'b1);
    pressKey(K_BS, 1'b0);
    checkOutput("bbs", 16'h6, 16'h123, 2'b01, 16'h123, 3'd3, 1'b0, 1'b0);

    // Reset taken while a command is pending.
    pressKey(K_EQ, 1'b0);
    checkOutput("hold", 16'h6, 16'h123, 2'b01, 16'h123, 3'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, K_ADD, 1'b0);
    checkOutput("rsthold", 16'h0, 16'h0, 2'b00, 16'h0, 3'd0, 1'b0, 1'b0);
    pressKey(hk(4'hC), 1'b0);
    checkOutput("after", 16'hC, 16'h0, 2'b00, 16'hC, 3'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
